// File: rtl/usrt_tx_framer.sv
// USRT transmit framer: FIFO-fed serialiser producing start / data (LSB first) /
// optional parity / one or two stop bits, advancing only on the usrt_pedge bit tick.

// Word FIFO between the host write port and the framer. Power-of-two depth so
// the pointers wrap by plain overflow.
module usrt_tx_framer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid_i,
    input  logic [W-1:0]                 wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         rd_en_i,
    output logic [W-1:0]                 rd_data_o,
    output logic                         not_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    // A pop is only honoured against the registered count, so a word written
    // this cycle is never visible to the reader in the same cycle.
    assign wr_ready_o  = (count_q < CNTW'(DEPTH));
    assign not_empty_o = (count_q != '0);
    assign do_push     = wr_valid_i && wr_ready_o;
    assign do_pop      = rd_en_i && not_empty_o;
    assign rd_data_o   = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset flushes the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care once the pointers are cleared
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

module usrt_tx_framer #(
    parameter int MAX_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               usrt_pedge,
    input  logic                               run_flag,
    input  logic                               size_flag,
    input  logic [1:0]                         parity_mode,
    input  logic                               stop2,
    input  logic [MAX_BITS-1:0]                din,
    input  logic                               din_valid,
    output logic                               din_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               busy,
    output logic                               rts,
    output logic                               txd
);
    localparam int CW = $clog2(MAX_BITS+1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                txd_q, txd_d;
    logic                rts_q, rts_d;
    logic [MAX_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    logic [CW-1:0]       nbits_q, nbits_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                stop2_q, stop2_d;
    logic                par_acc_q, par_acc_d;
    logic [1:0]          stopcnt_q, stopcnt_d;

    logic                pop;
    logic                have_word;
    logic [MAX_BITS-1:0] fifo_rd_data;
    logic                start_ok;
    logic [1:0]          nstop;

    usrt_tx_framer_fifo #(
        .W     (MAX_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_valid_i  (din_valid),
        .wr_data_i   (din),
        .wr_ready_o  (din_ready),
        .rd_en_i     (pop),
        .rd_data_o   (fifo_rd_data),
        .not_empty_o (have_word),
        .count_o     (fifo_count)
    );

    assign start_ok = run_flag && have_word;
    assign nstop    = stop2_q ? 2'd2 : 2'd1;

    // Next-state / output logic; nothing moves unless the bit tick is high
    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        rts_d     = rts_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        nbits_d   = nbits_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        par_acc_d = par_acc_q;
        stopcnt_d = stopcnt_q;
        pop       = 1'b0;

        if (usrt_pedge) begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        // Pop, latch this frame's configuration, drive start bit
                        pop       = 1'b1;
                        txd_d     = 1'b0;
                        rts_d     = 1'b1;
                        state_d   = DATA;
                        shreg_d   = fifo_rd_data;
                        bitcnt_d  = '0;
                        nbits_d   = size_flag ? CW'(MAX_BITS) : CW'(MAX_BITS-1);
                        par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_odd_d = (parity_mode == 2'b10);
                        stop2_d   = stop2;
                        par_acc_d = 1'b0;
                        stopcnt_d = '0;
                    end else begin
                        txd_d = 1'b1;
                        rts_d = 1'b0;
                    end
                end
                DATA: begin
                    // Parity accumulates only over bits actually sent, so an
                    // ignored top bit in short mode never affects it.
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    par_acc_d = par_acc_q ^ shreg_q[0];
                    bitcnt_d  = bitcnt_q + CW'(1);
                    if (bitcnt_q == nbits_q - CW'(1)) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        stopcnt_d = '0;
                    end
                end
                PARITY: begin
                    txd_d   = par_acc_q ^ par_odd_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (stopcnt_q == nstop) begin
                        // This tick ends the last stop bit: chain or go idle
                        if (start_ok) begin
                            pop       = 1'b1;
                            txd_d     = 1'b0;
                            rts_d     = 1'b1;
                            state_d   = DATA;
                            shreg_d   = fifo_rd_data;
                            bitcnt_d  = '0;
                            nbits_d   = size_flag ? CW'(MAX_BITS) : CW'(MAX_BITS-1);
                            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                            par_odd_d = (parity_mode == 2'b10);
                            stop2_d   = stop2;
                            par_acc_d = 1'b0;
                            stopcnt_d = '0;
                        end else begin
                            txd_d   = 1'b1;
                            rts_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        txd_d     = 1'b1;
                        stopcnt_d = stopcnt_q + 2'd1;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    rts_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Framer state registers; reset abandons any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            rts_q     <= 1'b0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            nbits_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            par_acc_q <= 1'b0;
            stopcnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            rts_q     <= rts_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            nbits_q   <= nbits_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            par_acc_q <= par_acc_d;
            stopcnt_q <= stopcnt_d;
        end
    end

    assign txd  = txd_q;
    assign rts  = rts_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_usrt_tx_framer.sv
// Directed bench for usrt_tx_framer: hand-computed bit sequences per frame.
module tb_usrt_tx_framer;
    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       usrt_pedge = 1'b0;
    logic       run_flag = 1'b0;
    logic       size_flag = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [2:0] fifo_count;
    logic       busy;
    logic       rts;
    logic       txd;

    int checks = 0;
    int failures = 0;

    usrt_tx_framer #(.MAX_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .usrt_pedge  (usrt_pedge),
        .run_flag    (run_flag),
        .size_flag   (size_flag),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .rts         (rts),
        .txd         (txd)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Bit tick: one clk wide every 16 clocks, changed on the falling edge
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            usrt_pedge = (cnt == 15);
            cnt = (cnt == 15) ? 0 : cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next clock edge that carried a tick
    task automatic next_bit();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!usrt_pedge && n < 100);
        #1;
        if (n >= 100) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        din = d;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 8; i++) begin
            next_bit();
            if (txd === 1'b0) break;
        end
        chk({tag, "_start"}, 32'(txd), 32'd0);
        chk({tag, "_rts_rise"}, 32'(rts), 32'd1);
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    endtask

    // Check bit positions [from..to-1] of a frame (position 0 = start bit)
    task automatic check_bits(input string tag, input logic [0:15] seq, input int from, input int to);
        for (int i = from; i < to; i++) begin
            next_bit();
            chk($sformatf("%s_bit%0d", tag, i), 32'(txd), 32'(seq[i]));
            chk($sformatf("%s_rts%0d", tag, i), 32'(rts), 32'd1);
        end
    endtask

    task automatic check_end(input string tag);
        next_bit();
        chk({tag, "_end_txd"}, 32'(txd), 32'd1);
        chk({tag, "_end_rts"}, 32'(rts), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_chain(input string tag);
        next_bit();
        chk({tag, "_b2b_start"}, 32'(txd), 32'd0);
        chk({tag, "_b2b_rts"}, 32'(rts), 32'd1);
    endtask

    initial begin
        // 1. Asynchronous reset with no clock running
        #3 rst = 1'b1;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rts", 32'(rts), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        #6 rst = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(negedge clk);

        // 2. 0xA5, 8 bits, no parity, 1 stop
        run_flag = 1'b1; size_flag = 1'b1; parity_mode = 2'b00; stop2 = 1'b0;
        push(8'hA5);
        wait_start("a5");
        check_bits("a5", 16'b0101001011_000000, 1, 10);
        check_end("a5");

        // 3. 0x41, 7 bits, even parity, 2 stop
        size_flag = 1'b0; parity_mode = 2'b01; stop2 = 1'b1;
        push(8'h41);
        wait_start("x41");
        check_bits("x41", 16'b01000001011_00000, 1, 11);
        check_end("x41");

        // 4. Odd parity, 8 bits: 0xFF -> parity 1, 0x01 -> parity 0
        size_flag = 1'b1; parity_mode = 2'b10; stop2 = 1'b0;
        push(8'hFF);
        wait_start("ff_odd");
        check_bits("ff_odd", 16'b01111111111_00000, 1, 11);
        check_end("ff_odd");
        push(8'h01);
        wait_start("x01_odd");
        check_bits("x01_odd", 16'b01000000001_00000, 1, 11);
        check_end("x01_odd");

        // 5. Fill FIFO with run off, overflow attempt, then back-to-back drain
        run_flag = 1'b0; parity_mode = 2'b00;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        chk("fill3_ready", 32'(din_ready), 32'd1);
        push(8'hAA);
        chk("full_ready", 32'(din_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        push(8'h0F);
        chk("overflow_count", 32'(fifo_count), 32'd4);
        chk("overflow_ready", 32'(din_ready), 32'd0);
        chk("overflow_idle_txd", 32'(txd), 32'd1);
        run_flag = 1'b1;
        wait_start("f0");
        chk("f0_count", 32'(fifo_count), 32'd3);
        check_bits("f0", 16'b0000000001_000000, 1, 10);
        check_chain("f0");
        check_bits("f1", 16'b0111111111_000000, 1, 10);
        check_chain("f1");
        check_bits("f2", 16'b0101010101_000000, 1, 10);
        check_chain("f2");
        check_bits("f3", 16'b0010101011_000000, 1, 10);
        check_end("f3");
        chk("drain_count", 32'(fifo_count), 32'd0);

        // 6a. Drop run_flag mid-data with two words queued
        run_flag = 1'b0;
        push(8'h3C);
        push(8'hC3);
        run_flag = 1'b1;
        wait_start("x3c");
        check_bits("x3c", 16'b0001111001_000000, 1, 3);
        run_flag = 1'b0;
        check_bits("x3c", 16'b0001111001_000000, 3, 10);
        check_end("x3c");
        chk("runoff_count", 32'(fifo_count), 32'd1);
        next_bit();
        next_bit();
        chk("runoff_hold_txd", 32'(txd), 32'd1);
        chk("runoff_hold_count", 32'(fifo_count), 32'd1);

        // 6b. Reset mid-frame flushes FIFO and forces idle outputs
        push(8'h81);
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        run_flag = 1'b1;
        wait_start("xc3");
        check_bits("xc3", 16'b0110000111_000000, 1, 4);
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd", 32'(txd), 32'd1);
        chk("midrst_rts", 32'(rts), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_ready", 32'(din_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        next_bit();
        next_bit();
        chk("post_rst_txd", 32'(txd), 32'd1);
        chk("post_rst_rts", 32'(rts), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usrt_tx_framer.md
# usrt_tx_framer

Parametrised USRT transmit framer: the next-generation output section of the USRT transmitter. It replaces the fixed alternating test pattern with real data words taken from an internal FIFO through a valid/ready handshake. Each frame is serialised as a start bit, 7- or 8-style variable-width data (LSB first), optional even/odd parity and one or two stop bits. All bit timing comes from the shared `usrt_pedge` bit tick.

## Interface

Parameters:
- `MAX_BITS`, default 8: full data width. Legal range is 5..9.
- `FIFO_DEPTH`, default 4: number of words the FIFO holds. Must be a power of 2 and ≥ 2.

Ports:
- `clk`, input, 1: the single clock. Every register is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high. Clears everything immediately.
- `usrt_pedge`, input, 1: bit tick, a 1-`clk` pulse once per bit period. All framer state changes happen only in cycles where it is high.
- `run_flag`, input, 1: transmit enable. Sampled only at frame boundaries.
- `size_flag`, input, 1: selects the data width. 1 = `MAX_BITS` data bits; 0 = `MAX_BITS`-1 data bits (the top bit of the word is ignored).
- `parity_mode`, input, 2: 00 = no parity, 01 = even, 10 = odd, 11 = no parity (reserved).
- `stop2`, input, 1: 1 = two stop bits, 0 = one stop bit.
- `din`, input, `MAX_BITS`: data word to write into the FIFO.
- `din_valid`, input, 1: write request.
- `din_ready`, output, 1: high when `fifo_count < FIFO_DEPTH`.
- `fifo_count`, output, clog2(`FIFO_DEPTH`+1): number of words currently in the FIFO.
- `busy`, output, 1: high whenever the state is not IDLE.
- `rts`, output, 1: request-to-send.
- `txd`, output, 1: serial line. Idles high.

## Operation

Reset values: `txd`=1, `rts`=0, `busy`=0, `fifo_count`=0, `din_ready`=1. State is IDLE and the FIFO is empty.

FIFO:
- A word is pushed in any cycle where `din_valid` && `din_ready`.
- A pop happens only from the framer, and only when the registered count is ≥ 1. A word pushed into an empty FIFO can therefore not be popped in the same cycle.
- Push and pop in the same cycle leave the count unchanged.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- When `din_valid` is high while full, nothing is written and no state changes.

Frame configuration:
- `size_flag`, `parity_mode` and `stop2` are latched when a word is popped.
- Changes to them mid-frame have no effect on that frame.
- N = number of data bits; P = 1 if parity is enabled, else 0; S = 1 + `stop2`.
- Parity is computed over the N transmitted bits only:
  - even: the parity bit makes the total count of ones even;
  - odd: the parity bit makes the total count of ones odd.

States (every transition below happens only on a `usrt_pedge` cycle):
- IDLE, `txd`=1. If `run_flag` && count ≥ 1: pop a word, `txd`←0 (start bit), `rts`←1, go to DATA. Otherwise stay in IDLE with `rts`←0.
- DATA: `txd`← the next data bit, LSB first. After N bits, go to PARITY if P=1, else to STOP.
- PARITY: `txd`← the parity bit, then go to STOP.
- STOP: `txd`←1 for S ticks. On the tick that ends the last stop bit:
  - if `run_flag` && count ≥ 1: pop the next word and send its start bit immediately (back-to-back, no idle bit), with `rts` held high;
  - otherwise go to IDLE with `txd`=1 and `rts`←0.
- Dropping `run_flag` mid-frame never truncates the frame. The frame completes and the remaining words stay in the FIFO.
- Asserting `rst` mid-frame forces the reset values immediately. The partial frame is abandoned and the FIFO is flushed.

## Timing

- `txd` and `rts` are registered. They change on the `clk` edge that ends the `usrt_pedge` cycle.
- Each bit lasts exactly one tick-to-tick interval.
- Frame length is 1+N+P+S bit periods.
- Latency:
  - from a push into an empty FIFO (with `run_flag` high, in IDLE) to the start bit: the first `usrt_pedge` at least 1 cycle after the push;
  - `din_ready` falls in the cycle after the push that fills the FIFO.
- `busy` rises together with the start bit and falls together with `rts`.
- `rts` goes 0→1 on the same edge as the start bit. It goes 1→0 on the edge that ends the final stop bit.
- If `usrt_pedge` stays low, all outputs hold their values indefinitely.

## Test plan

1. **Reset values:** assert `rst` asynchronously with no clock edge. Required: `txd`=1, `rts`=0, `busy`=0, `din_ready`=1, `fifo_count`=0.
2. **8-bit, no parity, 1 stop:** `MAX_BITS`=8, tick every 16 `clk`. Push 0xA5, `run_flag`=1, `size_flag`=1, `parity_mode`=00, `stop2`=0. Required `txd` per bit: 0,1,0,1,0,0,1,0,1,1. `rts` is high for exactly 10 bit periods, then drops.
3. **7-bit, even parity, 2 stop:** push 0x41 with `size_flag`=0, `parity_mode`=01, `stop2`=1. Required `txd`: 0,1,0,0,0,0,0,1,0,1,1, which is 11 bit periods.
4. **8-bit, odd parity:** push 0xFF with `parity_mode`=10. Required parity bit = 1. Repeat with 0x01: required parity bit = 0.
5. **FIFO full, then back-to-back frames:** with `run_flag`=0, push 5 words (0x00, 0xFF, 0x55, 0xAA, 0x0F) at `FIFO_DEPTH`=4. Required: `din_ready`=0 after the 4th push, 5th word rejected, `fifo_count`=4. Then set `run_flag`=1. Required: 4 contiguous frames with no idle bit between them, `rts` high throughout, data order preserved, `fifo_count` ends at 0.
6. **Mid-frame disturbances:**
   - Drop `run_flag` during the data bits of frame 1 with 2 words queued. Required: frame 1 completes, `rts` falls at the end of its stop bit, `fifo_count`=1 remains.
   - Assert `rst` mid-frame. Required: `txd`=1 and `rts`=0 immediately, `fifo_count`=0.
